alu_exec_unit: RTL

Parametrised execute stage replacing the combinational ALU decoder plus ALU pair in the datapath. It accepts decoded instruction fields (ALUOp, funct3, funct7, opcode bit 5) with operands over a valid/ready handshake. It completes base RV32I ALU ops in one cycle and RV32M multiply/divide ops iteratively. A one-entry output register carries the result, zero flag and destination tag to writeback.

---
 rtl/alu_pkg.sv | 67 ++++++
 rtl/alu_exec_unit_mdu_iter.sv | 96 +++++++++
 rtl/alu_exec_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALUOp, funct3 constants, internal
// ALU control enum, FSM states and the combinational instruction decode.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MDU = 7'b0000001;

  typedef enum logic [3:0] {
    CTRL_ADD, CTRL_SUB, CTRL_SLL, CTRL_SLT, CTRL_SLTU, CTRL_XOR,
    CTRL_SRL, CTRL_SRA, CTRL_OR, CTRL_AND, CTRL_MDU
  } alu_ctrl_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX} state_e;

  // funct7[5] selects sub only for R-type, but selects sra for both forms.
  function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op,
                                           input logic [2:0] f3,
                                           input logic [6:0] f7,
                                           input logic       op5,
                                           input logic       en_m);
    alu_ctrl_e c;
    c = CTRL_ADD;
    case (alu_op)
      ALUOP_ADD, ALUOP_RSVD: c = CTRL_ADD;
      ALUOP_SUB:             c = CTRL_SUB;
      default: begin
        if (en_m && op5 && (f7 == F7_MDU)) c = CTRL_MDU;
        else begin
          case (f3)
            F3_ADD:  c = (op5 && f7[5]) ? CTRL_SUB : CTRL_ADD;
            F3_SLL:  c = CTRL_SLL;
            F3_SLT:  c = CTRL_SLT;
            F3_SLTU: c = CTRL_SLTU;
            F3_XOR:  c = CTRL_XOR;
            F3_SR:   c = f7[5] ? CTRL_SRA : CTRL_SRL;
            F3_OR:   c = CTRL_OR;
            default: c = CTRL_AND;
          endcase
        end
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_exec_unit_mdu_iter.sv
// Iterative RV32M datapath: shift-add multiply and restoring divide on
// operand magnitudes, with sign and corner-case correction in the FIX result.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            cnt_zero_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, m_q, a_q;
  logic [2:0]      f3_q;
  logic            is_div_q, neg_res_q, neg_a_q, b_zero_q, ovf_q;

  logic            is_div, sa, sb, neg_a, neg_b, ovf;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, rsh, trial;
  logic [2*XLEN-1:0] prod_d;

  always_comb begin
    is_div = funct3_i[2];
    sa     = is_div ? !funct3_i[0] : (funct3_i == F3_MULH || funct3_i == F3_MULHSU);
    sb     = is_div ? !funct3_i[0] : (funct3_i == F3_MULH);
    neg_a  = sa && op_a_i[XLEN-1];
    neg_b  = sb && op_b_i[XLEN-1];
    mag_a  = neg_a ? -op_a_i : op_a_i;
    mag_b  = neg_b ? -op_b_i : op_b_i;
    ovf    = is_div && sa && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b_i);
  end

  // lo doubles as multiplier (shifted out) and as dividend/quotient (shifted in).
  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : {XLEN{1'b0}})};
    rsh     = {hi_q, lo_q[XLEN-1]};
    trial   = rsh - {1'b0, m_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0; hi_q <= '0; lo_q <= '0; m_q <= '0; a_q <= '0; f3_q <= '0;
      is_div_q <= 1'b0; neg_res_q <= 1'b0; neg_a_q <= 1'b0;
      b_zero_q <= 1'b0; ovf_q <= 1'b0;
    end else if (start_i) begin
      cnt_q     <= CW'(XLEN-1);
      hi_q      <= '0;
      lo_q      <= mag_a;
      m_q       <= mag_b;
      a_q       <= op_a_i;
      f3_q      <= funct3_i;
      is_div_q  <= is_div;
      neg_res_q <= neg_a ^ neg_b;
      neg_a_q   <= neg_a;
      b_zero_q  <= (op_b_i == '0);
      ovf_q     <= ovf;
    end else if (step_i) begin
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      if (is_div_q) begin
        if (!trial[XLEN]) begin
          hi_q <= trial[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= rsh[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign cnt_zero_o = (cnt_q == '0);

  always_comb begin
    prod_d = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    case (f3_q)
      F3_MUL:                          result_o = prod_d[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:    result_o = prod_d[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:
        result_o = b_zero_q ? {XLEN{1'b1}} : ovf_q ? a_q : (neg_res_q ? -lo_q : lo_q);
      default:
        result_o = b_zero_q ? a_q : ovf_q ? {XLEN{1'b0}} : (neg_a_q ? -hi_q : hi_q);
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle RV32I ALU ops, iterative RV32M ops through
// mdu_iter, and a one-entry result register towards writeback.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int ENABLE_M = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             op5,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int SW = $clog2(XLEN);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid on the same side.
  state_e           state_q;
  logic             out_valid_q, out_zero_q;
  logic [XLEN-1:0]  out_result_q, result_d, mdu_result;
  logic [TAG_W-1:0] out_tag_q, tag_pend_q;
  logic             accept, is_mdu, mdu_cnt_zero;
  logic [SW-1:0]    shamt;
  alu_ctrl_e        ctrl;

  assign ctrl     = alu_decode(alu_op, funct3, funct7, op5, ENABLE_M != 0);
  assign is_mdu   = (ctrl == CTRL_MDU);
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = op_b[SW-1:0];

  always_comb begin
    case (ctrl)
      CTRL_SUB:  result_d = op_a - op_b;
      CTRL_SLL:  result_d = op_a << shamt;
      CTRL_SLT:  result_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CTRL_SLTU: result_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      CTRL_XOR:  result_d = op_a ^ op_b;
      CTRL_SRL:  result_d = op_a >> shamt;
      CTRL_SRA:  result_d = $signed(op_a) >>> shamt;
      CTRL_OR:   result_d = op_a | op_b;
      CTRL_AND:  result_d = op_a & op_b;
      default:   result_d = op_a + op_b;
    endcase
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk        (clk),
    .rst        (rst),
    .start_i    (accept && is_mdu),
    .step_i     (state_q == ST_ITER),
    .funct3_i   (funct3),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .cnt_zero_o (mdu_cnt_zero),
    .result_o   (mdu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_tag_q    <= '0;
      tag_pend_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && is_mdu) begin
            state_q     <= ST_ITER;
            tag_pend_q  <= in_tag;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_result_q <= result_d;
            out_zero_q   <= (result_d == '0);
            out_tag_q    <= in_tag;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_ITER: begin
          if (out_ready) out_valid_q <= 1'b0;
          if (mdu_cnt_zero) state_q <= ST_FIX;
        end
        default: begin
          state_q      <= ST_IDLE;
          out_valid_q  <= 1'b1;
          out_result_q <= mdu_result;
          out_zero_q   <= (mdu_result == '0);
          out_tag_q    <= tag_pend_q;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_tag    = out_tag_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
